// File: rtl/lsu_pkg.sv
// Shared memory-control encodings, LSU state type and access-decoding helpers.
package lsu_pkg;

    localparam logic [2:0] MEM_LB  = 3'b000;
    localparam logic [2:0] MEM_LH  = 3'b001;
    localparam logic [2:0] MEM_LW  = 3'b010;
    localparam logic [2:0] MEM_LBU = 3'b011;
    localparam logic [2:0] MEM_LHU = 3'b100;
    localparam logic [2:0] MEM_SB  = 3'b101;
    localparam logic [2:0] MEM_SH  = 3'b110;
    localparam logic [2:0] MEM_SW  = 3'b111;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} lsu_state_e;

    function automatic logic is_load(input logic [2:0] ctrl);
        return ctrl <= MEM_LHU;
    endfunction

    function automatic logic is_aligned(input logic [2:0] ctrl, input logic [1:0] off);
        case (ctrl)
            MEM_LH, MEM_LHU, MEM_SH: return ~off[0];
            MEM_LW, MEM_SW:          return off == 2'b00;
            default:                 return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] gen_be(input logic [2:0] ctrl, input logic [1:0] off);
        case (ctrl)
            MEM_LB, MEM_LBU, MEM_SB: return 4'b0001 << off;
            MEM_LH, MEM_LHU, MEM_SH: return off[1] ? 4'b1100 : 4'b0011;
            default:                 return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_lsu_load_align.sv
// Picks the addressed byte/half lane out of a bus word and extends it for writeback.
module load_align
    import lsu_pkg::*;
(
    input  logic [2:0]  ctrl_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] word_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = word_i[{off_i, 3'b000} +: 8];
    assign half_lane = word_i[{off_i[1], 4'b0000} +: 16];

    always_comb begin
        data_o = '0;
        case (ctrl_i)
            MEM_LB:  data_o = {{24{byte_lane[7]}}, byte_lane};
            MEM_LBU: data_o = {24'h0, byte_lane};
            MEM_LH:  data_o = {{16{half_lane[15]}}, half_lane};
            MEM_LHU: data_o = {16'h0, half_lane};
            MEM_LW:  data_o = word_i;
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store unit: one word-addressed bus transaction per legal aligned access,
// pipeline stalled until ack or timeout.
module data_mem_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [2:0]        mem_ctrl,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              stall,
    output logic              misaligned,
    output logic              fault,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_ack
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    lsu_state_e        state_q;
    logic [2:0]        op_q;
    logic [1:0]        off_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       rdata_q, bus_wdata_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [3:0]        bus_be_q;
    logic              done_q, misaligned_q, fault_q, bus_req_q, bus_we_q;

    logic        legal, illegal, aligned, accept;
    logic [31:0] wdata_d, ld_data;

    assign legal   = (mem_rd & ~mem_wr &  is_load(mem_ctrl)) |
                     (mem_wr & ~mem_rd & ~is_load(mem_ctrl));
    assign illegal = (mem_rd | mem_wr) & ~legal;
    assign aligned = is_aligned(mem_ctrl, addr[1:0]);
    assign accept  = legal & aligned;

    always_comb begin
        wdata_d = wdata;
        case (mem_ctrl)
            MEM_SB:  wdata_d = {4{wdata[7:0]}};
            MEM_SH:  wdata_d = {2{wdata[15:0]}};
            default: wdata_d = wdata;
        endcase
    end

    load_align u_align (
        .ctrl_i (op_q),
        .off_i  (off_q),
        .word_i (bus_rdata),
        .data_o (ld_data)
    );

    // Stall only covers the accepting IDLE cycle and WAIT; DONE lets the pipe advance.
    assign stall = ((state_q == IDLE) & accept) | (state_q == WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= '0;
            off_q        <= '0;
            cnt_q        <= '0;
            rdata_q      <= '0;
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            fault_q      <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_be_q     <= '0;
            bus_wdata_q  <= '0;
        end else begin
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            fault_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (illegal) begin
                        fault_q <= 1'b1;
                    end else if (legal & ~aligned) begin
                        misaligned_q <= 1'b1;
                    end else if (accept) begin
                        state_q     <= WAIT;
                        op_q        <= mem_ctrl;
                        off_q       <= addr[1:0];
                        cnt_q       <= '0;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= mem_wr;
                        bus_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
                        bus_be_q    <= gen_be(mem_ctrl, addr[1:0]);
                        bus_wdata_q <= wdata_d;
                    end
                end
                WAIT: begin
                    // Ack takes priority over a timeout landing in the same cycle.
                    if (bus_ack) begin
                        rdata_q   <= ld_data;
                        done_q    <= 1'b1;
                        bus_req_q <= 1'b0;
                        bus_we_q  <= 1'b0;
                        bus_be_q  <= '0;
                        state_q   <= DONE;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        rdata_q   <= '0;
                        fault_q   <= 1'b1;
                        bus_req_q <= 1'b0;
                        bus_we_q  <= 1'b0;
                        bus_be_q  <= '0;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rdata      = rdata_q;
    assign done       = done_q;
    assign misaligned = misaligned_q;
    assign fault      = fault_q;
    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_be     = bus_be_q;
    assign bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed table-driven bench for data_mem_lsu with a tiny acking bus model.
module tb_data_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd, mem_wr;
    logic [2:0]  mem_ctrl;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        done, stall, misaligned, fault;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata, bus_rdata;
    logic        bus_ack;

    int nchecks = 0;
    int nerr    = 0;

    always #5 clk = ~clk;

    data_mem_lsu #(.ADDR_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ctrl(mem_ctrl),
        .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .stall(stall),
        .misaligned(misaligned), .fault(fault), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    typedef struct {
        string       name;
        logic        rd, wr;
        logic [2:0]  ctrl;
        logic [31:0] a, wd, brd;
        int          ack_at;   // WAIT-cycle index of ack; >= 4 means never
        int          e_req, e_done, e_fault, e_mis, e_stall;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic        e_we;
        logic [31:0] e_wd, e_rd;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int req_c = 0, done_c = 0, fault_c = 0, mis_c = 0, stall_c = 0, widx = 0;
        bit seen_req = 0, got_rd = 0;
        logic [31:0] c_addr = '0, c_wd = '0, c_rd = '0;
        logic [3:0]  c_be = '0;
        logic        c_we = 1'b0;
        @(posedge clk); #1;
        mem_rd = v.rd; mem_wr = v.wr; mem_ctrl = v.ctrl; addr = v.a; wdata = v.wd;
        #1;
        if (stall) stall_c++;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            mem_rd = 1'b0; mem_wr = 1'b0; bus_ack = 1'b0;
            #1;
            if (stall) stall_c++;
            if (done) begin done_c++; c_rd = rdata; got_rd = 1; end
            if (fault) begin
                fault_c++;
                if (seen_req) begin c_rd = rdata; got_rd = 1; end
            end
            if (misaligned) mis_c++;
            if (bus_req) begin
                if (!seen_req) begin
                    c_addr = bus_addr; c_be = bus_be; c_we = bus_we; c_wd = bus_wdata;
                end
                seen_req = 1;
                req_c++;
                if (widx == v.ack_at) begin bus_ack = 1'b1; bus_rdata = v.brd; end
                widx++;
            end
        end
        bus_ack = 1'b0;
        chk({v.name, " req_cycles"}, req_c, v.e_req);
        chk({v.name, " done_pulses"}, done_c, v.e_done);
        chk({v.name, " fault_pulses"}, fault_c, v.e_fault);
        chk({v.name, " misaligned_pulses"}, mis_c, v.e_mis);
        chk({v.name, " stall_cycles"}, stall_c, v.e_stall);
        if (v.e_req > 0) begin
            chk({v.name, " bus_addr"}, c_addr, v.e_addr);
            chk({v.name, " bus_be"}, {28'h0, c_be}, {28'h0, v.e_be});
            chk({v.name, " bus_we"}, {31'h0, c_we}, {31'h0, v.e_we});
            chk({v.name, " bus_wdata"}, c_wd, v.e_wd);
            chk({v.name, " rdata_seen"}, {31'h0, got_rd}, 32'h1);
            chk({v.name, " rdata"}, c_rd, v.e_rd);
        end
    endtask

    initial begin
        //            name        rd wr ctrl  addr          wdata         bus_rdata     ack req dn ft ms st  bus_addr      be       we  bus_wdata     rdata
        vecs[0]  = '{"LB",       1, 0, 3'd0, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0, 1, 1, 0, 0, 2, 32'h0000_0100, 4'b1000, 0, 32'h0,        32'hFFFF_FF80};
        vecs[1]  = '{"LBU",      1, 0, 3'd3, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0, 1, 1, 0, 0, 2, 32'h0000_0100, 4'b1000, 0, 32'h0,        32'h0000_0080};
        vecs[2]  = '{"LHU",      1, 0, 3'd4, 32'h0000_0102, 32'h0,        32'h8001_0000, 0, 1, 1, 0, 0, 2, 32'h0000_0100, 4'b1100, 0, 32'h0,        32'h0000_8001};
        vecs[3]  = '{"LH",       1, 0, 3'd1, 32'h0000_0102, 32'h0,        32'h8001_0000, 0, 1, 1, 0, 0, 2, 32'h0000_0100, 4'b1100, 0, 32'h0,        32'hFFFF_8001};
        vecs[4]  = '{"SH",       0, 1, 3'd6, 32'h0000_0202, 32'h1234_ABCD, 32'h5555_5555, 0, 1, 1, 0, 0, 2, 32'h0000_0200, 4'b1100, 1, 32'hABCD_ABCD, 32'h0};
        vecs[5]  = '{"LW_mis",   1, 0, 3'd2, 32'h0000_0101, 32'h0,        32'h0,         0, 0, 0, 0, 1, 0, 32'h0,        4'b0000, 0, 32'h0,        32'h0};
        vecs[6]  = '{"RDWR",     1, 1, 3'd2, 32'h0000_0100, 32'h0,        32'h0,         0, 0, 0, 1, 0, 0, 32'h0,        4'b0000, 0, 32'h0,        32'h0};
        vecs[7]  = '{"SW_tmo",   0, 1, 3'd7, 32'h0000_0300, 32'hDEAD_BEEF, 32'h0,        99, 4, 0, 1, 0, 5, 32'h0000_0300, 4'b1111, 1, 32'hDEAD_BEEF, 32'h0};
        vecs[8]  = '{"SW_last",  0, 1, 3'd7, 32'h0000_0300, 32'hDEAD_BEEF, 32'h1111_1111, 3, 4, 1, 0, 0, 5, 32'h0000_0300, 4'b1111, 1, 32'hDEAD_BEEF, 32'h0};
        vecs[9]  = '{"SB",       0, 1, 3'd5, 32'h0000_0005, 32'h0000_00A5, 32'h0,        2, 3, 1, 0, 0, 4, 32'h0000_0004, 4'b0010, 1, 32'hA5A5_A5A5, 32'h0};
        vecs[10] = '{"LB_dir",   0, 1, 3'd0, 32'h0000_0001, 32'h0,        32'h0,         0, 0, 0, 1, 0, 0, 32'h0,        4'b0000, 0, 32'h0,        32'h0};
        vecs[11] = '{"LH_mis",   1, 0, 3'd1, 32'h0000_0003, 32'h0,        32'h0,         0, 0, 0, 0, 1, 0, 32'h0,        4'b0000, 0, 32'h0,        32'h0};
        vecs[12] = '{"LW_post",  1, 0, 3'd2, 32'h0000_0010, 32'h0,        32'hCAFE_F00D, 1, 2, 1, 0, 0, 3, 32'h0000_0010, 4'b1111, 0, 32'h0,        32'hCAFE_F00D};

        rst = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; mem_ctrl = 3'd0;
        addr = '0; wdata = '0; bus_rdata = '0; bus_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset rdata", rdata, 32'h0);
        chk("reset pulses", {29'h0, done, misaligned, fault}, 32'h0);
        chk("reset bus ctl", {30'h0, bus_req, bus_we}, 32'h0);
        chk("reset bus_addr", bus_addr, 32'h0);
        chk("reset bus_be", {28'h0, bus_be}, 32'h0);
        chk("reset bus_wdata", bus_wdata, 32'h0);
        chk("reset stall", {31'h0, stall}, 32'h0);
        rst = 1'b0;

        // Stray ack while idle must not complete anything.
        @(posedge clk); #1;
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        chk("idle ack done", {31'h0, done}, 32'h0);
        chk("idle ack bus_req", {31'h0, bus_req}, 32'h0);

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Reset in the second WAIT cycle aborts silently.
        @(posedge clk); #1;
        mem_rd = 1'b1; mem_ctrl = 3'd2; addr = 32'h0000_0040;
        @(posedge clk); #1;
        mem_rd = 1'b0;
        chk("abort in WAIT bus_req", {31'h0, bus_req}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("abort bus ctl", {30'h0, bus_req, bus_we}, 32'h0);
        chk("abort bus_addr/be", {bus_addr[27:0], bus_be}, 32'h0);
        chk("abort pulses", {29'h0, done, misaligned, fault}, 32'h0);
        chk("abort stall", {31'h0, stall}, 32'h0);
        chk("abort rdata", rdata, 32'h0);
        @(posedge clk); #1;
        chk("after abort pulses", {29'h0, done, fault, bus_req}, 32'h0);

        run_vec(vecs[12]);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
